// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address width, stack pointer default
// and per-index reset value.
package regfile_pkg;

  localparam logic [31:0] DEF_SP_INIT = 32'h0100_0000;

  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Register 0 stays hardwired to zero even if the stack pointer index is set to 0.
  function automatic logic [63:0] reset_value(input int idx, input int sp_idx,
                                              input logic [63:0] sp_init);
    return (idx != 0 && idx == sp_idx) ? sp_init : 64'd0;
  endfunction

endpackage

// File: rtl/rf_wr_resolve.sv
// Priority select across all write ports for one queried register index.
// Highest-numbered matching port wins; index 0 and out-of-range indices never hit.
module rf_wr_resolve
  import regfile_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int NREGS  = 32,
  parameter int NWR    = 2,
  parameter int AW     = 5
) (
  input  logic [AW-1:0]                 addr_i,
  input  logic [NWR-1:0]                wr_en_i,
  input  logic [NWR-1:0][AW-1:0]        wr_addr_i,
  input  logic [NWR-1:0][DWIDTH-1:0]    wr_data_i,
  output logic                          hit_o,
  output logic [DWIDTH-1:0]             data_o
);

  logic addr_live;

  assign addr_live = (addr_i != '0) && (int'(addr_i) < NREGS);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (addr_live) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p] == addr_i)) begin
          hit_o  = 1'b1;
          data_o = wr_data_i[p];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with priority write resolution, write-through bypass,
// optional registered read and a pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                DWIDTH  = 32,
  parameter int                NREGS   = 32,
  parameter int                NRD     = 2,
  parameter int                NWR     = 2,
  parameter int                SP_IDX  = 2,
  parameter logic [DWIDTH-1:0] SP_INIT = DWIDTH'(DEF_SP_INIT),
  parameter int                RD_REG  = 0,
  localparam int               AW      = calc_aw(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NRD-1:0][AW-1:0]        rd_addr_i,
  output logic [NRD-1:0][DWIDTH-1:0]    rd_data_o,
  output logic [NRD-1:0]                rd_busy_o,
  input  logic [NWR-1:0]                wr_en_i,
  input  logic [NWR-1:0][AW-1:0]        wr_addr_i,
  input  logic [NWR-1:0][DWIDTH-1:0]    wr_data_i,
  input  logic                          iss_valid_i,
  input  logic [AW-1:0]                 iss_rd_i,
  input  logic                          flush_i,
  output logic [NREGS-1:0]              busy_o
);

  logic [DWIDTH-1:0]             regs_q [NREGS];
  logic [DWIDTH-1:0]             regs_d [NREGS];
  logic [NREGS-1:0]              busy_q, busy_d;
  logic [NREGS-1:0]              wr_hit;
  logic [NREGS-1:0][DWIDTH-1:0]  wr_dat;
  logic [NRD-1:0]                byp_hit;
  logic [NRD-1:0][DWIDTH-1:0]    byp_dat;
  logic [NRD-1:0][DWIDTH-1:0]    rd_val;

  for (genvar r = 0; r < NREGS; r++) begin : g_wr
    rf_wr_resolve #(.DWIDTH(DWIDTH), .NREGS(NREGS), .NWR(NWR), .AW(AW)) u_wr (
      .addr_i    (AW'(r)),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .hit_o     (wr_hit[r]),
      .data_o    (wr_dat[r])
    );
  end

  // Same resolver on the read addresses gives write-through bypass.
  for (genvar k = 0; k < NRD; k++) begin : g_byp
    rf_wr_resolve #(.DWIDTH(DWIDTH), .NREGS(NREGS), .NWR(NWR), .AW(AW)) u_byp (
      .addr_i    (rd_addr_i[k]),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .hit_o     (byp_hit[k]),
      .data_o    (byp_dat[k])
    );
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = wr_hit[r] ? wr_dat[r] : regs_q[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= DWIDTH'(reset_value(r, SP_IDX, 64'(SP_INIT)));
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_val[k]    = '0;
      rd_busy_o[k] = 1'b0;
      if ((rd_addr_i[k] != '0) && (int'(rd_addr_i[k]) < NREGS)) begin
        rd_val[k]    = byp_hit[k] ? byp_dat[k] : regs_q[rd_addr_i[k]];
        rd_busy_o[k] = busy_q[rd_addr_i[k]];
      end
    end
  end

  // Issue outranks flush and writeback so a reissued destination stays pending.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (iss_valid_i && (int'(iss_rd_i) == r)) begin
        busy_d[r] = 1'b1;
      end else if (flush_i || wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

  if (RD_REG != 0) begin : g_rd_reg
    logic [NRD-1:0][DWIDTH-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_val;
      end
    end
    assign rd_data_o = rd_q;
  end else begin : g_rd_comb
    assign rd_data_o = rd_val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp, comparing a combinational-read and a
// registered-read instance against an array-based reference model.
module tb_regfile_mp;

  localparam int          DW    = 32;
  localparam int          NR    = 32;
  localparam int          NRD   = 2;
  localparam int          NWR   = 2;
  localparam int          AW    = 5;
  localparam logic [31:0] SPV   = 32'h0100_0000;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NRD-1:0][AW-1:0]     rd_addr;
  logic [NWR-1:0]             wr_en;
  logic [NWR-1:0][AW-1:0]     wr_addr;
  logic [NWR-1:0][DW-1:0]     wr_data;
  logic                       iss_valid;
  logic [AW-1:0]              iss_rd;
  logic                       flush;

  logic [NRD-1:0][DW-1:0]     rd_data0, rd_data1;
  logic [NRD-1:0]             rd_busy0, rd_busy1;
  logic [NR-1:0]              busy0, busy1;

  int checks = 0;
  int errors = 0;
  bit chk    = 1'b0;

  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic [DW-1:0] m_rdq  [NRD];

  always #5 clk = ~clk;

  regfile_mp #(.DWIDTH(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR), .SP_IDX(2),
               .SP_INIT(SPV), .RD_REG(0)) dut0 (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data0), .rd_busy_o(rd_busy0),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .iss_valid_i(iss_valid),
    .iss_rd_i(iss_rd), .flush_i(flush), .busy_o(busy0)
  );

  regfile_mp #(.DWIDTH(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR), .SP_IDX(2),
               .SP_INIT(SPV), .RD_REG(1)) dut1 (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data1), .rd_busy_o(rd_busy1),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .iss_valid_i(iss_valid),
    .iss_rd_i(iss_rd), .flush_i(flush), .busy_o(busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value a reader sees this cycle: last write to that index wins, x0 is always zero.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && wr_addr[p] == a) v = wr_data[p];
    return v;
  endfunction

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic cycle();
    logic [DW-1:0] nxt [NRD];
    #2;
    if (chk) begin
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("rd0[%0d] a=%0d", k, rd_addr[k]), 64'(rd_data0[k]), 64'(model_read(rd_addr[k])));
        check($sformatf("rd1[%0d]", k), 64'(rd_data1[k]), 64'(m_rdq[k]));
        check($sformatf("rdbusy0[%0d]", k), 64'(rd_busy0[k]), 64'(m_busy[rd_addr[k]]));
        check($sformatf("rdbusy1[%0d]", k), 64'(rd_busy1[k]), 64'(m_busy[rd_addr[k]]));
      end
      check("busy0", 64'(busy0), 64'(m_busy));
      check("busy1", 64'(busy1), 64'(m_busy));
    end
    for (int k = 0; k < NRD; k++) nxt[k] = model_read(rd_addr[k]);
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NR; r++) m_regs[r] = '0;
      m_regs[2] = SPV;
      m_busy    = '0;
      for (int k = 0; k < NRD; k++) m_rdq[k] = '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p] != 0) begin
          m_regs[wr_addr[p]] = wr_data[p];
          m_busy[wr_addr[p]] = 1'b0;
        end
      end
      if (flush) m_busy = '0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      for (int k = 0; k < NRD; k++) m_rdq[k] = nxt[k];
    end
    chk = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    rd_addr = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();
    idle();

    // Reset values
    rd_addr[0] = 5'd2; rd_addr[1] = 5'd5;
    #2;
    check("reset_x2", 64'(rd_data0[0]), 64'(SPV));
    check("reset_x5", 64'(rd_data0[1]), 64'd0);
    check("reset_busy", 64'(busy0), 64'd0);
    check("reset_rdreg", 64'(rd_data1[0]), 64'd0);
    cycle();

    // Two ports to x5 in the same cycle: port1 wins
    wr_en = 2'b11; wr_addr[0] = 5'd5; wr_data[0] = 32'hAAAA;
    wr_addr[1] = 5'd5; wr_data[1] = 32'hBBBB;
    rd_addr[0] = 5'd5;
    #2;
    check("prio_bypass", 64'(rd_data0[0]), 64'h0000_BBBB);
    cycle();
    idle();
    #2;
    check("prio_stored", 64'(rd_data0[0]), 64'h0000_BBBB);
    cycle();

    // x0 write and issue ignored
    wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF;
    iss_valid = 1'b1; iss_rd = 5'd0; rd_addr[0] = 5'd0;
    cycle();
    idle();
    #2;
    check("x0_read", 64'(rd_data0[0]), 64'd0);
    check("x0_busy", 64'(busy0[0]), 64'd0);
    cycle();

    // Issue beats same-cycle writeback
    iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h77;
    rd_addr[1] = 5'd7;
    cycle();
    idle();
    #2;
    check("iss_over_wb", 64'(busy0[7]), 64'd1);
    wr_en = 2'b10; wr_addr[1] = 5'd7; wr_data[1] = 32'h78;
    cycle();
    idle();
    #2;
    check("wb_clear", 64'(busy0[7]), 64'd0);
    cycle();

    // Flush, then flush with simultaneous issue
    iss_valid = 1'b1; iss_rd = 5'd3; cycle();
    iss_rd = 5'd9; cycle();
    idle(); flush = 1'b1; cycle();
    idle();
    #2;
    check("flush_all", 64'(busy0), 64'd0);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
    cycle();
    idle();
    #2;
    check("flush_iss", 64'(busy0), 64'h10);
    cycle();

    // Registered read sees the bypassed write one cycle later
    rd_addr[0] = 5'd6; wr_en = 2'b01; wr_addr[0] = 5'd6; wr_data[0] = 32'h1234;
    cycle();
    idle();
    #2;
    check("rdreg_bypass", 64'(rd_data1[0]), 64'h1234);
    cycle();

    // Randomized traffic with colliding addresses and occasional reset/flush
    for (int i = 0; i < 300; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      wr_en     = NWR'($urandom);
      for (int p = 0; p < NWR; p++) begin
        wr_addr[p] = AW'($urandom_range(0, 9));
        wr_data[p] = $urandom;
      end
      for (int k = 0; k < NRD; k++) rd_addr[k] = AW'($urandom_range(0, 9));
      iss_valid = $urandom_range(0, 1);
      iss_rd    = AW'($urandom_range(0, 9));
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // Reset overrides concurrent writes, issue and flush
    rst = 1'b1; wr_en = 2'b11; wr_addr[0] = 5'd2; wr_data[0] = 32'hDEAD;
    wr_addr[1] = 5'd5; wr_data[1] = 32'hBEEF; iss_valid = 1'b1; iss_rd = 5'd5;
    cycle();
    idle();
    rd_addr[0] = 5'd2; rd_addr[1] = 5'd5;
    #2;
    check("rst_x2", 64'(rd_data0[0]), 64'(SPV));
    check("rst_x5", 64'(rd_data0[1]), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_rdreg", 64'(rd_data1[0]), 64'd0);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
